// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } state_t;

    // One bit time at 10 MHz / 19200 baud; used as the default inter-frame gap.
    localparam int CLKS_PER_BIT_DEFAULT = 521;

    // Ceiling log2, never less than 1 so index buses always have a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
`timescale 1ns/1ps
// Combinational round-robin pick: first set request searching upward from ptr+1.
// Latency: 0 clocks (pure combinational).
// Backpressure: none; the caller decides when to take the grant.
//
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - index of the last served requester
//   gnt  - one-hot grant (all zero when no request)
//   idx  - index of the granted requester (0 when no request)
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pos;

    // Walk from the farthest candidate back to the nearest so the nearest
    // set request after ptr is the last (winning) assignment.
    always_comb begin
        gnt = '0;
        idx = '0;
        pos = '0;
        for (int k = N; k >= 1; k--) begin
            pos = IW'((int'(ptr) + k) % N);
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Shares one UART TX engine among NUM_REQ byte sources, round-robin with frame locking.
// Latency: 1 clk arbitration, handshake -> tx_start 1 clk, busy fall -> next ISSUE 1 clk.
// Backpressure: req_ready only to the owner in ISSUE while the engine is idle.
//
// Ports:
//   tx_clk, tx_rst          - clock, synchronous active-high reset
//   req_valid/data/last     - per-requester byte stream (requester i at data[8i+7:8i])
//   req_ready               - one-hot accept to the current owner
//   tx_data, tx_start       - byte and start pulse to the engine
//   tx_busy                 - engine busy, high from after tx_start to end of stop bit
//   grant_id, grant_active  - current owner and frame ownership flag
//   frame_abort             - pulse when an owner stalls past HOLD_MAX clocks mid-frame
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int GAP_CLKS = CLKS_PER_BIT_DEFAULT,
    parameter int HOLD_MAX = 5210,
    parameter int CNT_W    = 16
) (
    input  logic                        tx_clk,
    input  logic                        tx_rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [8*NUM_REQ-1:0]        req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    output logic [clog2(NUM_REQ)-1:0]   grant_id,
    output logic                        grant_active,
    output logic                        frame_abort
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    // Unused when GAP_CLKS is 0 because the GAP state is never entered.
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CLKS - 1);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic               last_q;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   gap_cnt;

    logic [NUM_REQ-1:0] win_gnt;
    logic [IDX_W-1:0]   win_idx;
    logic               own_ready;
    logic               own_hs;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    assign own_ready = (state == ISSUE) && !tx_busy;
    assign own_hs    = own_ready && req_valid[grant_id];
    assign req_ready = own_ready ? (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state        <= IDLE;
            rr_ptr       <= IDX_W'(NUM_REQ - 1);
            last_q       <= 1'b0;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            frame_abort  <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (|win_gnt) begin
                        grant_id     <= win_idx;
                        grant_active <= 1'b1;
                        hold_cnt     <= '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (own_hs) begin
                        tx_data  <= req_data[{grant_id, 3'b000} +: 8];
                        last_q   <= req_last[grant_id];
                        tx_start <= 1'b1;
                        hold_cnt <= '0;
                        state    <= WAIT_ACK;
                    end else if (!req_valid[grant_id]) begin
                        // Owner stalled mid-frame: force the frame closed once the
                        // hold budget is spent so other sources are not starved.
                        if (hold_cnt == HOLD_LAST) begin
                            frame_abort <= 1'b1;
                            hold_cnt    <= '0;
                            rr_ptr      <= grant_id;
                            if (GAP_CLKS == 0) begin
                                grant_active <= 1'b0;
                                state        <= IDLE;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            rr_ptr <= grant_id;
                            if (GAP_CLKS == 0) begin
                                grant_active <= 1'b0;
                                state        <= IDLE;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt      <= '0;
                        grant_active <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: queue-driven requesters, a byte-timed engine model,
// and a frame-level round-robin reference. A second instance runs with no gap.
module tb_uart_tx_arbiter;

    localparam int N_REQ     = 4;
    localparam int GAP_N     = 3;
    localparam int HOLD_N    = 8;
    localparam int CPB       = 4;
    localparam int BYTE_CLKS = 10 * CPB;
    localparam int LIMIT     = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 4 requesters, short gap, short hold budget.
    logic               rst;
    logic [N_REQ-1:0]   req_valid, req_last, req_ready;
    logic [8*N_REQ-1:0] req_data;
    logic [7:0]         tx_data;
    logic               tx_start, tx_busy, grant_active, frame_abort;
    logic [1:0]         grant_id;

    uart_tx_arbiter #(.NUM_REQ(N_REQ), .GAP_CLKS(GAP_N), .HOLD_MAX(HOLD_N), .CNT_W(16)) dut (
        .tx_clk(clk), .tx_rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .grant_id(grant_id), .grant_active(grant_active),
        .frame_abort(frame_abort)
    );

    // Instance B: 2 requesters, no gap.
    logic        b_rst;
    logic [1:0]  b_valid, b_last, b_ready;
    logic [15:0] b_data;
    logic [7:0]  b_tx_data;
    logic        b_start, b_busy, b_ga, b_abort;
    logic [0:0]  b_gid;

    uart_tx_arbiter #(.NUM_REQ(2), .GAP_CLKS(0), .HOLD_MAX(HOLD_N), .CNT_W(16)) dut_b (
        .tx_clk(clk), .tx_rst(b_rst), .req_valid(b_valid), .req_data(b_data),
        .req_last(b_last), .req_ready(b_ready), .tx_data(b_tx_data), .tx_start(b_start),
        .tx_busy(b_busy), .grant_id(b_gid), .grant_active(b_ga), .frame_abort(b_abort)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Requester byte queues: {last, data}; the head is presented whenever present.
    logic [8:0] dq [N_REQ][$];
    logic [9:0] obs[$];
    logic [9:0] exp_q[$];

    initial begin
        logic [N_REQ-1:0] hs;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready & {N_REQ{!rst}};
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (hs[i] && dq[i].size() > 0) void'(dq[i].pop_front());
                if (dq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_last[i]        = dq[i][0][8];
                    req_data[8*i +: 8] = dq[i][0][7:0];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_last[i]        = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
    end

    // Engine model A: busy for BYTE_CLKS clocks after each tx_start.
    int         eng_cnt = 0;
    logic [7:0] eng_byte = '0;
    bit         eng_rst = 0, ga_prev = 0;
    int         fall_cyc = -1, ga_fall_cyc = -1, abort_dist = -1;
    int         n_start = 0, n_abort = 0, n_overlap = 0;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) eng_rst = 1;
            if (tx_busy) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    tx_busy  = 1'b0;
                    fall_cyc = cyc;
                    if (!eng_rst) check_eq("tx_data_stable", tx_data, eng_byte);
                end
            end
            if (tx_start) begin
                n_start++;
                obs.push_back({grant_id, tx_data});
                if (tx_busy) n_overlap++;
                tx_busy  = 1'b1;
                eng_cnt  = BYTE_CLKS;
                eng_byte = tx_data;
                eng_rst  = 0;
            end
            if (frame_abort) begin
                n_abort++;
                abort_dist = cyc - fall_cyc;
            end
            if (ga_prev && !grant_active) ga_fall_cyc = cyc;
            ga_prev = grant_active;
        end
    end

    // Driver and engine model B.
    logic [8:0] b_obs[$];
    int b_cnt = 0, b_fall_cyc = -1, b_space = -1, b_abort_seen = 0;

    initial begin
        logic [1:0] hs;
        b_valid = '0;
        b_last  = '0;
        b_data  = '0;
        forever begin
            @(negedge clk);
            hs = b_valid & b_ready & {2{!b_rst}};
            @(posedge clk);
            #1;
            b_valid = b_valid & ~hs;
        end
    end

    initial begin
        b_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (b_busy) begin
                b_cnt--;
                if (b_cnt == 0) begin
                    b_busy     = 1'b0;
                    b_fall_cyc = cyc;
                end
            end
            if (b_start) begin
                b_obs.push_back({b_gid, b_tx_data});
                if (b_fall_cyc >= 0) b_space = cyc - b_fall_cyc;
                b_busy = 1'b1;
                b_cnt  = BYTE_CLKS;
            end
            if (b_abort) b_abort_seen++;
        end
    end

    function automatic bit all_empty();
        for (int i = 0; i < N_REQ; i++) begin
            if (dq[i].size() != 0) return 0;
        end
        return 1;
    endfunction

    // Frame-level reference: all frames are queued before release, so service
    // order is pure round-robin over requesters with frames, whole frame at a time.
    task automatic build_expected();
        logic [8:0] mq [N_REQ][$];
        logic [8:0] e;
        int ptr;
        bit found;
        exp_q.delete();
        for (int i = 0; i < N_REQ; i++) mq[i] = dq[i];
        ptr = N_REQ - 1;
        while (1) begin
            found = 0;
            for (int k = 1; k <= N_REQ && !found; k++) begin
                int j;
                j = (ptr + k) % N_REQ;
                if (mq[j].size() > 0) begin
                    found = 1;
                    ptr   = j;
                    do begin
                        e = mq[j].pop_front();
                        exp_q.push_back({2'(j), e[7:0]});
                    end while (!e[8] && mq[j].size() > 0);
                end
            end
            if (!found) break;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq(tag, {15'd0, tx_start, frame_abort, grant_active, grant_id, tx_data, req_ready}, 32'd0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            tick(1);
            t++;
        end while (!(all_empty() && !grant_active && !tx_busy) && t < LIMIT);
        check_eq("idle_reached", 32'(t < LIMIT), 32'd1);
    endtask

    task automatic run_round(input string tag);
        int m;
        build_expected();
        obs.delete();
        tick(1);
        rst = 1'b0;
        wait_idle();
        check_eq({tag, "_len"}, obs.size(), exp_q.size());
        m = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int k = 0; k < m; k++) check_eq(tag, obs[k], exp_q[k]);
        rst = 1'b1;
        tick(1);
        check_reset_outputs({tag, "_rst"});
    endtask

    initial begin
        int s0, a0, t, nb, nf;
        rst   = 1'b1;
        b_rst = 1'b1;
        tick(3);
        check_reset_outputs("reset_a");
        check_eq("reset_b", {b_start, b_abort, b_ga, b_gid, b_tx_data, b_ready}, 32'd0);

        // Single one-byte frame; gap of GAP_N clocks after the busy fall edge's
        // WAIT_DONE exit before ownership drops.
        dq[0].push_back({1'b1, 8'hA5});
        s0 = n_start;
        run_round("single");
        check_eq("single_starts", n_start - s0, 1);
        check_eq("gap_release", ga_fall_cyc - fall_cyc, 1 + GAP_N);

        // Round-robin between 1 and 2 with wrap.
        dq[1].push_back({1'b1, 8'h31}); dq[1].push_back({1'b1, 8'h32});
        dq[2].push_back({1'b1, 8'h41}); dq[2].push_back({1'b1, 8'h42});
        run_round("rr");

        // Frame locking: requester 3's frame is not interleaved with requester 0.
        dq[0].push_back({1'b1, 8'h44}); dq[0].push_back({1'b1, 8'h55});
        dq[3].push_back({1'b0, 8'h11}); dq[3].push_back({1'b0, 8'h22});
        dq[3].push_back({1'b1, 8'h33});
        run_round("lock");

        // Hold timeout: owner 0 stalls after a non-last byte.
        dq[0].push_back({1'b0, 8'h10});
        dq[1].push_back({1'b1, 8'h55});
        obs.delete();
        a0 = n_abort;
        tick(1);
        rst = 1'b0;
        wait_idle();
        check_eq("abort_count", n_abort - a0, 1);
        // ISSUE is re-entered one clock after the busy fall; abort follows HOLD_N later.
        check_eq("abort_timing", abort_dist, 1 + HOLD_N);
        check_eq("abort_len", obs.size(), 2);
        if (obs.size() == 2) begin
            check_eq("abort_byte0", obs[0], {2'd0, 8'h10});
            check_eq("abort_next", obs[1], {2'd1, 8'h55});
        end
        rst = 1'b1;
        tick(1);

        // Reset during WAIT_DONE drops the frame; arbitration restarts at 0.
        dq[2].push_back({1'b0, 8'hC1}); dq[2].push_back({1'b0, 8'hC2});
        dq[2].push_back({1'b1, 8'hC3});
        s0 = n_start;
        tick(1);
        rst = 1'b0;
        t = 0;
        while (n_start == s0 && t < 200) begin
            tick(1);
            t++;
        end
        check_eq("midframe_started", 32'(n_start > s0), 32'd1);
        tick(3);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("reset_midframe");
        for (int i = 0; i < N_REQ; i++) dq[i].delete();
        dq[3].push_back({1'b1, 8'h77});
        dq[0].push_back({1'b1, 8'h66});
        run_round("after_reset");

        // Randomized frame mixes.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N_REQ; i++) begin
                nf = $urandom_range(0, 2);
                for (int f = 0; f < nf; f++) begin
                    nb = $urandom_range(1, 3);
                    for (int b = 0; b < nb; b++) dq[i].push_back({b == nb - 1, 8'($urandom)});
                end
            end
            run_round("rand");
        end
        check_eq("no_start_overlap", n_overlap, 0);

        // No-gap instance: second frame starts 3 clocks after busy falls.
        b_valid = 2'b11;
        b_last  = 2'b11;
        b_data  = {8'hB1, 8'hB0};
        tick(1);
        b_rst = 1'b0;
        t = 0;
        while (!(b_valid == 2'b00 && !b_ga && !b_busy) && t < LIMIT) begin
            tick(1);
            t++;
        end
        check_eq("b_done", 32'(t < LIMIT), 32'd1);
        check_eq("b_len", b_obs.size(), 2);
        if (b_obs.size() == 2) begin
            check_eq("b_first", b_obs[0], {1'b0, 8'hB0});
            check_eq("b_second", b_obs[1], {1'b1, 8'hB1});
        end
        check_eq("b2b_spacing", 32'(b_space >= 1 && b_space <= 3), 32'd1);
        check_eq("b_no_abort", b_abort_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
